// File: rtl/wb_select_pipe.sv
// N-way writeback result select with a registered valid/ready output and a 2-entry skid buffer.
// Optional build macro SEL_ERR_CNT_EN adds an 8-bit saturating out-of-range select counter.
module wb_select_pipe #(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 5,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_sel_err,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef SEL_ERR_CNT_EN
   ,
   output logic [7:0]              sel_err_cnt
`endif
);

   logic [WIDTH-1:0] dec_data;
   logic             dec_err;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic             skid_valid;
   logic             accept;
   logic             drain;

   // Out-of-range selects fall through the loop and yield zero data with the error flag set.
   always_comb begin
      dec_data = '0;
      dec_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            dec_data = in_data[k*WIDTH +: WIDTH];
            dec_err  = 1'b0;
         end
      end
   end

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sel_err <= 1'b0;
         skid_valid  <= 1'b0;
         skid_data   <= '0;
         skid_err    <= 1'b0;
      end else if (flush) begin
         // Data registers keep their contents; only the valid bits drop.
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         case ({out_valid, skid_valid})
            2'b00: begin
               if (accept) begin
                  out_valid   <= 1'b1;
                  out_data    <= dec_data;
                  out_sel_err <= dec_err;
               end
            end
            2'b10: begin
               if (accept && drain) begin
                  out_data    <= dec_data;
                  out_sel_err <= dec_err;
               end else if (accept) begin
                  skid_valid <= 1'b1;
                  skid_data  <= dec_data;
                  skid_err   <= dec_err;
               end else if (drain) begin
                  out_valid <= 1'b0;
               end
            end
            2'b11: begin
               if (drain) begin
                  out_data    <= skid_data;
                  out_sel_err <= skid_err;
                  skid_valid  <= 1'b0;
               end
            end
            default: begin
               out_valid  <= 1'b0;
               skid_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEL_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sel_err_cnt <= 8'd0;
      else if (accept && dec_err && sel_err_cnt != 8'hff)
         sel_err_cnt <= sel_err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_wb_select_pipe.sv
// Bench for wb_select_pipe: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_wb_select_pipe;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 5;
   localparam int SEL_W  = $clog2(NUM_IN);

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    flush;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_sel_err;
   logic                    out_valid;
   logic                    out_ready;
`ifdef SEL_ERR_CNT_EN
   logic [7:0]              sel_err_cnt;
`endif

   wb_select_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEL_ERR_CNT_EN
      , .sel_err_cnt(sel_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             err;
   } entry_t;

   logic [WIDTH-1:0] words[NUM_IN];
   entry_t           mq[$];
   int               mcnt;

   typedef struct {
      logic             v;
      logic [SEL_W-1:0] sel;
      logic             ordy;
      logic             fl;
      logic             ov;
      logic [WIDTH-1:0] d;
      logic             e;
      logic             ir;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pack_words();
      for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = words[k];
   endtask

   // Reference model: a FIFO of at most two decoded results; acceptance only when not full.
   task automatic cycle();
      bit acc, drn;
      entry_t ent;
      @(posedge clk);
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      ent.data = (int'(in_sel) < NUM_IN) ? words[in_sel] : '0;
      ent.err  = (int'(in_sel) >= NUM_IN);
      if (acc && ent.err && mcnt < 255) mcnt++;
      if (flush) mq.delete();
      else begin
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(ent);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic r, input logic f);
      in_valid = v; in_sel = s; out_ready = r; flush = f;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mq.delete();
      mcnt = 0;
      drive(0, 0, 0, 0);
      #1;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_sel_err", 32'(out_sel_err), 0);
`ifdef SEL_ERR_CNT_EN
      chk("reset_cnt", 32'(sel_err_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic vec_t mk(logic v, logic [SEL_W-1:0] s, logic r, logic f,
                               logic ov, logic [WIDTH-1:0] d, logic e, logic ir);
      vec_t t;
      t.v = v; t.sel = s; t.ordy = r; t.fl = f; t.ov = ov; t.d = d; t.e = e; t.ir = ir;
      return t;
   endfunction

   initial begin
      tbl[0]  = mk(1, 3, 1, 0, 1, 32'h1000_0003, 0, 1);
      tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
      tbl[2]  = mk(1, 6, 1, 0, 1, 32'h0, 1, 1);
      tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
      tbl[4]  = mk(1, 1, 0, 0, 1, 32'h1000_0001, 0, 1);
      tbl[5]  = mk(1, 2, 0, 0, 1, 32'h1000_0001, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 32'h1000_0001, 0, 0);
      tbl[7]  = mk(0, 0, 1, 0, 1, 32'h1000_0002, 0, 1);
      tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0, 0, 1, 32'h1000_0000, 0, 1);
      tbl[10] = mk(1, 1, 0, 0, 1, 32'h1000_0000, 0, 0);
      tbl[11] = mk(1, 4, 0, 1, 0, 0, 0, 1);
      tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 1);
      tbl[13] = mk(1, 2, 0, 0, 1, 32'h1000_0002, 0, 1);
      tbl[14] = mk(1, 3, 1, 1, 0, 0, 0, 1);
      tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 1);
      tbl[16] = mk(1, 4, 1, 0, 1, 32'h1000_0004, 0, 1);
      tbl[17] = mk(1, 7, 1, 0, 1, 32'h0, 1, 1);
      tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 1);

      for (int k = 0; k < NUM_IN; k++) words[k] = 32'h1000_0000 + k;
      pack_words();
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].v, tbl[i].sel, tbl[i].ordy, tbl[i].fl);
         cycle();
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
         if (tbl[i].ov) begin
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].d);
            chk($sformatf("vec%0d_out_sel_err", i), 32'(out_sel_err), 32'(tbl[i].e));
         end
`ifdef SEL_ERR_CNT_EN
         if (i == 2) chk("vec2_cnt", 32'(sel_err_cnt), 1);
`endif
      end

      // Full throughput: one result per cycle, in order, ready never drops.
      for (int i = 0; i < 8; i++) begin
         drive(1, SEL_W'(i % 5), 1, 0);
         cycle();
         chk($sformatf("thru%0d_out_valid", i), 32'(out_valid), 1);
         chk($sformatf("thru%0d_out_data", i), out_data, 32'h1000_0000 + (i % 5));
         chk($sformatf("thru%0d_in_ready", i), 32'(in_ready), 1);
      end
      drive(0, 0, 1, 0);
      cycle();
      chk("thru_idle_out_valid", 32'(out_valid), 0);

      // Async reset while full, asserted between clock edges.
      drive(1, 1, 0, 0); cycle();
      drive(1, 6, 0, 0); cycle();
      drive(0, 0, 0, 0);
      chk("prereset_in_ready", 32'(in_ready), 0);
      #2;
      do_reset();

      // Random traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NUM_IN; k++) words[k] = $urandom;
         pack_words();
         drive($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 7)),
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         cycle();
         chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
         chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 2));
         if (mq.size() > 0) begin
            chk("rnd_out_data", out_data, mq[0].data);
            chk("rnd_out_sel_err", 32'(out_sel_err), 32'(mq[0].err));
         end
`ifdef SEL_ERR_CNT_EN
         chk("rnd_cnt", 32'(sel_err_cnt), mcnt);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
Parametrised N-way result-select stage for the Rx32 writeback path, the next generation of the fixed 5-input combinational result mux. It registers the selected operand behind a valid/ready handshake and includes a 2-entry skid buffer, so upstream and downstream stalls are decoupled without a combinational ready path. Out-of-range selects produce deterministic zero data plus an error flag instead of X. A synchronous flush discards buffered results on a pipeline redirect.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 5, number of selectable inputs (legal range 2..16)
SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all buffered entries
in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
in_sel  in  SEL_W  binary select, sampled with in_valid
in_valid  in  1  upstream presents a transfer
in_ready  out  1  stage can accept a transfer
out_data  out  WIDTH  selected, registered result
out_sel_err  out  1  result came from an out-of-range select
out_valid  out  1  out_data/out_sel_err are valid
out_ready  in  1  downstream accepts the result

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel_err=0, skid entry empty, in_ready=1. Release is synchronous to clk.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Select: in_sel < NUM_IN gives data = input[in_sel] and err=0. in_sel >= NUM_IN gives data = 0 and err=1. Decode happens at capture; the registered result is stored.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or is draining in the same cycle.
- Storage: output register (main) plus one skid register, for 2 entries total.
  - in_ready = !skid_valid. in_ready is registered and has no combinational dependence on out_ready.
- State (from {main_valid, skid_valid}):
  - EMPTY {0,0}: an accept loads main and moves to ONE.
  - ONE {1,0}:
    - accept with no drain: load skid, move to FULL.
    - drain with no accept: move to EMPTY.
    - accept and drain together: load main, stay in ONE.
  - FULL {1,1}: in_ready=0. A drain moves skid to main, clears skid, and moves to ONE.
- Ordering: strict FIFO. Skid always holds the younger entry.
- Flush (priority over all other events):
  - Next cycle: main_valid=0, skid_valid=0, in_ready=1.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes (downstream already sampled it).
  - out_data is not cleared by flush; only valid drops.
- Reset during operation: all entries are discarded immediately and asynchronously; no partial transfer survives.
- Stability: while out_valid && !out_ready, out_data and out_sel_err are held constant.

Optional Feature:
SEL_ERR_CNT_EN
- Defined: adds output port sel_err_cnt, 8 bits.
  - Increments by 1 on each accepted input transfer with an out-of-range select.
  - Saturates at 255.
  - Reset to 0 by rst_n only; flush does not clear it.
- Not defined: the port and counter do not exist. The rest of the behaviour is identical.

Test Plan:
- Reset then single transfer: NUM_IN=5, in_data input k = 32'h1000_0000+k, in_sel=3, in_valid one cycle, out_ready=1 -> next cycle out_valid=1, out_data=32'h1000_0003, out_sel_err=0. Following cycle out_valid=0.
- Illegal select: in_sel=6 accepted -> out_data=32'h0, out_sel_err=1. With SEL_ERR_CNT_EN, sel_err_cnt=1.
- Backpressure/skid: out_ready=0, send sel=1 then sel=2 back to back -> in_ready=0 after the second transfer and out_data holds input 1. Raise out_ready -> outputs input 1, then input 2 on consecutive cycles. in_ready returns to 1 the cycle after the first drain.
- Full throughput: out_ready=1, in_valid=1 for 8 cycles with sel cycling 0..4 -> 8 results in order, one per cycle, in_ready=1 throughout.
- Flush: stage FULL, assert flush along with in_valid and sel=4 -> next cycle out_valid=0, in_ready=1. The sel=4 transfer never appears at the output.
- Async reset mid-stream: assert rst_n low between clock edges while FULL -> out_valid=0 and in_ready=1 without waiting for a clock edge. With SEL_ERR_CNT_EN, sel_err_cnt=0.
